// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-cache request/response bus between the memory-access stage and the cache
interface mem_access_stage_if #(
    parameter int ADDR_W = 64
);
    logic              dreq_valid;
    logic              dreq_ready;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_we;
    logic [63:0]       dreq_wdata;
    logic [7:0]        dreq_wstrb;
    logic              dresp_valid;
    logic [63:0]       dresp_rdata;

    modport master (
        output dreq_valid,
        output dreq_addr,
        output dreq_we,
        output dreq_wdata,
        output dreq_wstrb,
        input  dreq_ready,
        input  dresp_valid,
        input  dresp_rdata
    );

    modport slave (
        input  dreq_valid,
        input  dreq_addr,
        input  dreq_we,
        input  dreq_wdata,
        input  dreq_wstrb,
        output dreq_ready,
        output dresp_valid,
        output dresp_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage: issues data-cache loads/stores and produces writeback results
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int RESP_TIMEOUT = 256,
    parameter int ADDR_W       = 64
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_stage_if.master dbus,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_aluresult,
    input  logic [63:0] ex_store_data,
    input  logic [5:0]  ex_dest_reg,
    input  logic [1:0]  ex_mem_op,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    output logic        wb_valid,
    output logic [5:0]  wb_dest_reg,
    output logic [63:0] wb_data,
    output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap,
    output logic [63:0] misalign_addr
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

    localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    state_t            state_q;
    logic              ex_ready_q;
    logic              dreq_valid_q;
    logic [ADDR_W-1:0] dreq_addr_q;
    logic              dreq_we_q;
    logic [63:0]       dreq_wdata_q;
    logic [7:0]        dreq_wstrb_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [5:0]        dest_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wb_valid_q;
    logic [5:0]        wb_dest_q;
    logic [63:0]       wb_data_q;
    logic              bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              trap_q;
    logic [63:0]       trap_addr_q;
    logic              misaligned;
`endif

    logic              is_mem;
    logic [2:0]        ex_off;
    logic [7:0]        byte_mask;
    logic [7:0]        wstrb_d;
    logic [63:0]       wdata_d;
    logic [ADDR_W-1:0] addr_full;
    logic [ADDR_W-1:0] addr_d;
    logic [63:0]       rd_shifted;
    logic [63:0]       load_d;

    always_comb begin
        is_mem    = (ex_mem_op == 2'b01) || (ex_mem_op == 2'b10);
        ex_off    = ex_aluresult[2:0];
        byte_mask = 8'h01;
        case (ex_size)
            2'b00:   byte_mask = 8'h01;
            2'b01:   byte_mask = 8'h03;
            2'b10:   byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
        // Lanes past byte 7 fall off the top of both the strobe and the data.
        wstrb_d   = byte_mask << ex_off;
        wdata_d   = ex_store_data << {ex_off, 3'b000};
        addr_full = ADDR_W'(ex_aluresult);
        addr_d    = {addr_full[ADDR_W-1:3], 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        case (ex_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_off[0];
            2'b10:   misaligned = |ex_off[1:0];
            default: misaligned = |ex_off;
        endcase
`endif
    end

    always_comb begin
        rd_shifted = dbus.dresp_rdata >> {off_q, 3'b000};
        load_d     = rd_shifted;
        case (size_q)
            2'b00:   load_d = uns_q ? {56'd0, rd_shifted[7:0]}
                                    : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_d = uns_q ? {48'd0, rd_shifted[15:0]}
                                    : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            2'b10:   load_d = uns_q ? {32'd0, rd_shifted[31:0]}
                                    : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            default: load_d = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ex_ready_q   <= 1'b1;
            dreq_valid_q <= 1'b0;
            dreq_addr_q  <= '0;
            dreq_we_q    <= 1'b0;
            dreq_wdata_q <= '0;
            dreq_wstrb_q <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            dest_q       <= '0;
            cnt_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
            bus_err_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            trap_q       <= 1'b0;
            trap_addr_q  <= '0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (ex_valid && ex_ready_q) begin
                        if (is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                            if (misaligned) begin
                                trap_q      <= 1'b1;
                                trap_addr_q <= ex_aluresult;
                            end else
`endif
                            begin
                                state_q      <= REQ;
                                ex_ready_q   <= 1'b0;
                                dreq_valid_q <= 1'b1;
                                dreq_addr_q  <= addr_d;
                                dreq_we_q    <= (ex_mem_op == 2'b10);
                                dreq_wdata_q <= wdata_d;
                                dreq_wstrb_q <= wstrb_d;
                                off_q        <= ex_off;
                                size_q       <= ex_size;
                                uns_q        <= ex_unsigned;
                                dest_q       <= ex_dest_reg;
                            end
                        end else begin
                            wb_valid_q <= (ex_dest_reg != 6'd0);
                            wb_dest_q  <= ex_dest_reg;
                            wb_data_q  <= ex_aluresult;
                        end
                    end
                end
                REQ: begin
                    if (dbus.dreq_ready) begin
                        dreq_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        if (dreq_we_q) begin
                            state_q    <= IDLE;
                            ex_ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    // A response on the expiry cycle takes priority over the timeout.
                    if (dbus.dresp_valid) begin
                        wb_valid_q <= (dest_q != 6'd0);
                        wb_dest_q  <= dest_q;
                        wb_data_q  <= load_d;
                        state_q    <= IDLE;
                        ex_ready_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        bus_err_q  <= 1'b1;
                        wb_valid_q <= (dest_q != 6'd0);
                        wb_dest_q  <= dest_q;
                        wb_data_q  <= '0;
                        state_q    <= IDLE;
                        ex_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ex_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ex_ready        = ex_ready_q;
    assign dbus.dreq_valid = dreq_valid_q;
    assign dbus.dreq_addr  = dreq_addr_q;
    assign dbus.dreq_we    = dreq_we_q;
    assign dbus.dreq_wdata = dreq_wdata_q;
    assign dbus.dreq_wstrb = dreq_wstrb_q;
    assign wb_valid        = wb_valid_q;
    assign wb_dest_reg     = wb_dest_q;
    assign wb_data         = wb_data_q;
    assign bus_err         = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_trap   = trap_q;
    assign misalign_addr   = trap_addr_q;
`endif
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result, destination register and load/store control from execute, and performs data-cache reads and writes over a valid/ready request and valid response interface.
- Produces one writeback result per instruction for the register file.
- Back-pressures execute through ex_ready while a memory transaction is outstanding.

Parameters:
- RESP_TIMEOUT, 256: maximum cycles spent in WAIT_RESP before the load is aborted with bus_err.
- ADDR_W, 64: address width; must be at least 3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts the instruction (replaces data_ack toward execute)
- ex_aluresult  in  64  ALU result; this is the effective address for loads and stores
- ex_store_data  in  64  rs2 value for stores
- ex_dest_reg  in  6  destination register
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_size  in  2  00 byte, 01 half, 10 word, 11 double
- ex_unsigned  in  1  zero-extend the load result
- dreq_valid  out  1  cache request valid
- dreq_ready  in  1  cache accepts the request
- dreq_addr  out  ADDR_W  8-byte-aligned address
- dreq_we  out  1  1 = store
- dreq_wdata  out  64  lane-shifted store data
- dreq_wstrb  out  8  byte strobes
- dresp_valid  in  1  read data valid
- dresp_rdata  in  64  read data
- wb_valid  out  1  one-cycle writeback pulse
- wb_dest_reg  out  6  writeback register
- wb_data  out  64  writeback value
- bus_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, ex_ready=1. All other outputs are 0, including dreq_*, wb_*, bus_err and the timeout counter.
- Reset asserted mid-transaction: dreq_valid drops immediately. Any outstanding response is ignored after reset is released.
- States: IDLE, REQ, WAIT_RESP.
- ex_ready=1 only in IDLE. An instruction is accepted on ex_valid && ex_ready.

Non-memory op accepted at cycle T:
- At T+1: wb_valid=1, wb_data=ex_aluresult, wb_dest_reg=ex_dest_reg.
- State stays IDLE, so back-to-back non-memory ops give full throughput.

Load or store accepted at T:
- Register all request fields; state goes to REQ.
- dreq_valid=1 from T+1 and held, with all fields stable, until dreq_ready.
- Address and lane mapping: off = addr[2:0]; dreq_addr = addr with bits[2:0] cleared; dreq_wstrb = ((1<<bytes)-1)<<off, truncated to 8 bits; dreq_wdata = ex_store_data<<(8*off).
- For loads, dreq_wstrb carries the read byte mask and dreq_we=0.

Store:
- On the dreq handshake, return to IDLE. No wb_valid is produced and any dresp for the store is ignored.

Load:
- On the dreq handshake, go to WAIT_RESP.
- On dresp_valid: take (dresp_rdata>>(8*off)), keep the low 8*bytes bits, then sign-extend, or zero-extend if ex_unsigned. Double-word loads ignore ex_unsigned.
- The result is presented the next cycle as a wb_valid pulse; state returns to IDLE.
- dresp_valid arriving in the same cycle as the dreq handshake is ignored. A response is only valid from WAIT_RESP.

Timeout:
- The counter starts at 0 on entering WAIT_RESP and increments each cycle.
- If it reaches RESP_TIMEOUT-1 without dresp_valid: bus_err pulses, wb_valid pulses with wb_data=0, and state returns to IDLE.
- dresp_valid in the same cycle as expiry wins: the data is written back and bus_err stays 0.

Writeback rules:
- ex_dest_reg==0: wb_valid is suppressed for every op. The memory access still occurs.
- wb_valid is never asserted in two consecutive cycles for memory ops. Non-memory ops may give consecutive pulses.
- dresp_valid while in IDLE or REQ is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: an access is misaligned when addr is not a multiple of its size. A misaligned load or store issues no dreq and does not write back. Instead, for one cycle at T+1, outputs misalign_trap (1 bit) and misalign_addr (64 bits) are driven; state stays IDLE.
- Undefined: those ports do not exist. Misaligned accesses are issued normally; bytes beyond lane 7 are dropped by the strobe and shift truncation rules.

Test Plan:
- Non-memory op, dest=5, aluresult=0x1234 -> wb_valid=1 at T+1, wb_dest_reg=5, wb_data=0x1234, no dreq; two back-to-back non-memory ops give wb_valid pulses on consecutive cycles.
- Load byte signed at addr 0x1003, dresp_rdata=0x00000000_80000000 -> dreq_addr=0x1000, wstrb=0x08, wb_data=0xFFFFFFFF_FFFFFF80; same with ex_unsigned=1 -> 0x80.
- Store half at 0x2006, data=0xBEEF, dreq_ready held low for 3 cycles -> dreq fields stable for those 3 cycles, wstrb=0xC0, wdata=0xBEEF<<48, ex_ready=0 until the cycle after the handshake, no wb_valid.
- Load, no dresp, RESP_TIMEOUT=4 -> bus_err and wb_valid pulse 4 cycles after entering WAIT_RESP with wb_data=0; a second run with dresp_valid on the expiry cycle -> data written back, bus_err=0.
- Reset (reset=0) asserted while in REQ -> dreq_valid=0 immediately; after release ex_ready=1 and a stale dresp_valid produces no wb_valid.
- With MEM_MISALIGN_TRAP_EN: word load at 0x3002 -> misalign_trap=1, misalign_addr=0x3002, no dreq_valid, no wb_valid.
